// File: rtl/serial_deserializer.sv
// -----------------------------------------------------------------------------
// serial_deserializer
//
// Serial-to-parallel input stage. LSB-first serial bits are shifted into a
// WIDTH-bit register. When the frame is complete, the word is presented on
// data_out together with a one-cycle data_valid strobe. An optional trailing
// parity bit can be checked. data_out feeds the downstream data register
// stage, and data_valid is that stage's load qualifier.
//
// Parameters:
//   WIDTH       data bits per frame (>= 2)
//   PARITY_EN   1 = one parity bit follows the data bits, 0 = none
//   ODD_PARITY  0 = even parity, 1 = odd parity (ignored without parity)
//
// Ports:
//   clk          in   single clock, rising-edge
//   rst_n        in   synchronous active-low reset
//   frame_start  in   one-cycle pulse; arms or re-arms (aborts) reception
//   bit_in       in   serial data bit, sampled only when bit_valid = 1
//   bit_valid    in   qualifies bit_in
//   data_out     out  last completed word, held between frames
//   data_valid   out  one-cycle pulse when data_out has just been updated
//   parity_err   out  parity result of the last completed frame
//   busy         out  high while a frame is in progress
// -----------------------------------------------------------------------------
module serial_deserializer #(
    parameter int WIDTH      = 8,
    parameter int PARITY_EN  = 1,
    parameter int ODD_PARITY = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             frame_start,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic             parity_err,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic ODD_BIT = (ODD_PARITY != 0);
    localparam logic HAS_PARITY = (PARITY_EN != 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] bit_cnt;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] shifted;

    // Word as it looks after the bit on the wire is shifted in. It is used
    // directly on completion when there is no parity bit.
    assign shifted = {bit_in, sreg[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            sreg       <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            busy       <= 1'b0;
        end else begin
            data_valid <= 1'b0;

            // frame_start takes priority over any bit in the same cycle. It
            // also wins over a final data/parity bit, so an aborted frame
            // never completes.
            if (frame_start) begin
                state   <= SHIFT;
                bit_cnt <= '0;
                sreg    <= '0;
                busy    <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        // Bits outside a frame are ignored.
                    end

                    SHIFT: begin
                        if (bit_valid) begin
                            sreg    <= shifted;
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt == LAST_BIT) begin
                                if (HAS_PARITY) begin
                                    state <= PAR;
                                end else begin
                                    data_out   <= shifted;
                                    data_valid <= 1'b1;
                                    parity_err <= 1'b0;
                                    busy       <= 1'b0;
                                    bit_cnt    <= '0;
                                    state      <= IDLE;
                                end
                            end
                        end
                    end

                    PAR: begin
                        if (bit_valid) begin
                            // The XOR over data and parity must equal
                            // ODD_PARITY for a good frame.
                            data_out   <= sreg;
                            data_valid <= 1'b1;
                            parity_err <= ((^sreg) ^ bit_in) != ODD_BIT;
                            busy       <= 1'b0;
                            bit_cnt    <= '0;
                            state      <= IDLE;
                        end
                    end

                    default: begin
                        state   <= IDLE;
                        bit_cnt <= '0;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
